// File: rtl/ysyx_exu_mul_sched_pkg.sv
// Shared EXU package: build-time sizes, the M-unit scheduler state encoding
// and small decode helpers used by the multiply/divide scheduler.
`ifndef YSYX_XLEN
`define YSYX_XLEN 32
`endif
`ifndef YSYX_RS_SIZE
`define YSYX_RS_SIZE 4
`endif
`ifndef YSYX_ROB_SIZE
`define YSYX_ROB_SIZE 8
`endif

package ysyx_pkg;
  localparam int YSYX_XLEN_P     = `YSYX_XLEN;
  localparam int YSYX_RS_SIZE_P  = `YSYX_RS_SIZE;
  localparam int YSYX_ROB_SIZE_P = `YSYX_ROB_SIZE;

  localparam logic [4:0] ALU_OP_MUL = 5'b10000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    DRAIN = 3'd4
  } mul_sched_state_t;

  // One extra bit over the ROB index so that tag 0 can mean "no tag".
  function automatic int tag_width(input int rob_size);
    return $clog2(rob_size) + 1;
  endfunction

  function automatic logic is_m_op(input logic [4:0] alu_op);
    return alu_op[4];
  endfunction
endpackage

// File: rtl/ysyx_exu_mul_sched_age_sel.sv
// Oldest-first selector: picks the valid entry whose ROB tag is closest to
// rob_head (modulo the tag space); equal ages resolve to the lowest index.
module ysyx_exu_age_sel #(
  parameter int N     = 4,
  parameter int TAG_W = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]       valid,
  input  logic [N*TAG_W-1:0] dest,
  input  logic [TAG_W-1:0]   rob_head,
  output logic [N-1:0]       onehot,
  output logic [IDX_W-1:0]   index,
  output logic               found
);
  logic [TAG_W-1:0] age_s [N];
  logic [TAG_W-1:0] best_age_s;
  logic             take_s;

  for (genvar g = 0; g < N; g++) begin : g_age
    assign age_s[g] = dest[g*TAG_W +: TAG_W] - rob_head;
  end

  // Linear min-scan; strict less-than keeps the earlier index on a tie.
  always_comb begin
    found      = 1'b0;
    index      = '0;
    best_age_s = '0;
    take_s     = 1'b0;
    for (int i = 0; i < N; i++) begin
      take_s     = valid[i] && (!found || (age_s[i] < best_age_s));
      found      = found || take_s;
      best_age_s = take_s ? age_s[i] : best_age_s;
      index      = take_s ? IDX_W'(i) : index;
    end
    onehot = found ? (N'(1'b1) << index) : '0;
  end
endmodule

// File: rtl/ysyx_exu_mul_sched.sv
// Shares the single multi-cycle M unit between RS entries: grants the oldest
// ready request, issues it, and returns the tagged result; drains on flush.
module ysyx_exu_mul_sched
  import ysyx_pkg::*;
#(
  parameter  int XLEN     = YSYX_XLEN_P,
  parameter  int RS_SIZE  = YSYX_RS_SIZE_P,
  parameter  int ROB_SIZE = YSYX_ROB_SIZE_P,
  localparam int TAG_W    = tag_width(ROB_SIZE),
  localparam int IDX_W    = $clog2(RS_SIZE)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    flush_pipeline,
  input  logic [TAG_W-1:0]        rob_head,
  input  logic [RS_SIZE-1:0]      req_valid,
  input  logic [RS_SIZE*XLEN-1:0] req_a,
  input  logic [RS_SIZE*XLEN-1:0] req_b,
  input  logic [RS_SIZE*5-1:0]    req_op,
  input  logic [RS_SIZE*TAG_W-1:0] req_dest,
  output logic [RS_SIZE-1:0]      grant,
  output logic                    mul_in_valid,
  output logic [XLEN-1:0]         mul_in_a,
  output logic [XLEN-1:0]         mul_in_b,
  output logic [4:0]              mul_in_op,
  input  logic                    mul_out_valid,
  input  logic [XLEN-1:0]         mul_out_r,
  output logic                    res_valid,
  output logic [IDX_W-1:0]        res_index,
  output logic [TAG_W-1:0]        res_dest,
  output logic [XLEN-1:0]         res_data,
  input  logic                    res_ready,
  output logic                    sched_busy
);
  mul_sched_state_t state_r, state_nxt_s;

  logic [RS_SIZE-1:0] m_valid_s, sel_onehot_s;
  logic [IDX_W-1:0]   sel_index_s, idx_r;
  logic               sel_found_s, take_s, capture_s;
  logic [XLEN-1:0]    a_arr_s [RS_SIZE];
  logic [XLEN-1:0]    b_arr_s [RS_SIZE];
  logic [4:0]         op_arr_s [RS_SIZE];
  logic [TAG_W-1:0]   dest_arr_s [RS_SIZE];
  logic [XLEN-1:0]    a_r, b_r, res_data_r;
  logic [4:0]         op_r;
  logic [TAG_W-1:0]   dest_r;

  for (genvar g = 0; g < RS_SIZE; g++) begin : g_unpack
    assign a_arr_s[g]    = req_a[g*XLEN +: XLEN];
    assign b_arr_s[g]    = req_b[g*XLEN +: XLEN];
    assign op_arr_s[g]   = req_op[g*5 +: 5];
    assign dest_arr_s[g] = req_dest[g*TAG_W +: TAG_W];
    assign m_valid_s[g]  = req_valid[g] & is_m_op(op_arr_s[g]);
  end

  ysyx_exu_age_sel #(.N(RS_SIZE), .TAG_W(TAG_W), .IDX_W(IDX_W)) u_age_sel (
    .valid    (m_valid_s),
    .dest     (req_dest),
    .rob_head (rob_head),
    .onehot   (sel_onehot_s),
    .index    (sel_index_s),
    .found    (sel_found_s)
  );

  // Next-state logic; flush wins everywhere, but a started op must still drain.
  always_comb begin
    state_nxt_s = state_r;
    take_s      = 1'b0;
    capture_s   = 1'b0;
    case (state_r)
      IDLE: begin
        take_s      = sel_found_s && !flush_pipeline;
        state_nxt_s = take_s ? ISSUE : IDLE;
      end
      ISSUE: begin
        capture_s   = mul_out_valid && !flush_pipeline;
        state_nxt_s = flush_pipeline ? IDLE : (mul_out_valid ? DONE : WAIT);
      end
      WAIT: begin
        capture_s = mul_out_valid && !flush_pipeline;
        if (mul_out_valid) begin
          state_nxt_s = flush_pipeline ? IDLE : DONE;
        end else begin
          state_nxt_s = flush_pipeline ? DRAIN : WAIT;
        end
      end
      DONE:    state_nxt_s = (flush_pipeline || res_ready) ? IDLE : DONE;
      DRAIN:   state_nxt_s = mul_out_valid ? IDLE : DRAIN;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register plus the latched request and captured result.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      a_r        <= '0;
      b_r        <= '0;
      op_r       <= '0;
      dest_r     <= '0;
      idx_r      <= '0;
      res_data_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      if (take_s) begin
        a_r    <= a_arr_s[sel_index_s];
        b_r    <= b_arr_s[sel_index_s];
        op_r   <= op_arr_s[sel_index_s];
        dest_r <= dest_arr_s[sel_index_s];
        idx_r  <= sel_index_s;
      end
      if (capture_s) begin
        res_data_r <= mul_out_r;
      end
    end
  end

  // Grant is also masked by reset so every output reads 0 while held in reset.
  assign grant        = (take_s && reset) ? sel_onehot_s : '0;
  assign mul_in_valid = (state_r == ISSUE) && !flush_pipeline;
  assign mul_in_a     = a_r;
  assign mul_in_b     = b_r;
  assign mul_in_op    = op_r;
  assign res_valid    = (state_r == DONE);
  assign res_index    = idx_r;
  assign res_dest     = dest_r;
  assign res_data     = res_data_r;
  assign sched_busy   = (state_r != IDLE);
endmodule

// File: tb/tb_ysyx_exu_mul_sched.sv
// Self-checking bench for ysyx_exu_mul_sched with a fixed-latency M-unit model
// and a result scoreboard filled from the bench's own stimulus.
module tb_ysyx_exu_mul_sched;
  localparam int XLEN = 32;
  localparam int RS   = 4;
  localparam int TW   = 4;
  localparam int L    = 3;
  localparam int TMO  = 40;

  typedef struct packed {
    logic [1:0]      idx;
    logic [TW-1:0]   dest;
    logic [XLEN-1:0] data;
  } exp_t;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              flush_pipeline = 1'b0;
  logic [TW-1:0]     rob_head = '0;
  logic [RS-1:0]     req_valid = '0;
  logic [RS*XLEN-1:0] req_a = '0;
  logic [RS*XLEN-1:0] req_b = '0;
  logic [RS*5-1:0]   req_op = {RS{5'b10000}};
  logic [RS*TW-1:0]  req_dest = '0;
  logic [RS-1:0]     grant;
  logic              mul_in_valid;
  logic [XLEN-1:0]   mul_in_a, mul_in_b;
  logic [4:0]        mul_in_op;
  logic              mul_out_valid = 1'b0;
  logic [XLEN-1:0]   mul_out_r = '0;
  logic              res_valid;
  logic [1:0]        res_index;
  logic [TW-1:0]     res_dest;
  logic [XLEN-1:0]   res_data;
  logic              res_ready = 1'b0;
  logic              sched_busy;

  int   n_chk = 0;
  int   n_fail = 0;
  exp_t exp_q[$];

  ysyx_exu_mul_sched dut (
    .clock(clock), .reset(reset), .flush_pipeline(flush_pipeline), .rob_head(rob_head),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_dest(req_dest),
    .grant(grant), .mul_in_valid(mul_in_valid), .mul_in_a(mul_in_a), .mul_in_b(mul_in_b),
    .mul_in_op(mul_in_op), .mul_out_valid(mul_out_valid), .mul_out_r(mul_out_r),
    .res_valid(res_valid), .res_index(res_index), .res_dest(res_dest), .res_data(res_data),
    .res_ready(res_ready), .sched_busy(sched_busy)
  );

  always #5 clock = ~clock;

  // M-unit model: start sampled mid-cycle, one-cycle result pulse L cycles later.
  initial begin
    int          cnt_m;
    logic        start_m;
    logic [XLEN-1:0] pend_m;
    cnt_m  = 0;
    pend_m = '0;
    forever begin
      @(negedge clock);
      start_m = (mul_in_valid === 1'b1);
      if (start_m) pend_m = mul_in_a * mul_in_b;
      @(posedge clock);
      #1;
      if (start_m) cnt_m = L;
      if (cnt_m > 0) begin
        cnt_m--;
        mul_out_valid = (cnt_m == 0);
        mul_out_r     = (cnt_m == 0) ? pend_m : '0;
      end else begin
        mul_out_valid = 1'b0;
        mul_out_r     = '0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required the sequence to finish");
    $fatal(1);
  end

  function automatic exp_t mk(input logic [1:0] idx, input logic [TW-1:0] dest, input logic [XLEN-1:0] data);
    exp_t e;
    e.idx  = idx;
    e.dest = dest;
    e.data = data;
    return e;
  endfunction

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic set_entry(input int i, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input logic [TW-1:0] d);
    req_a[i*XLEN +: XLEN] = a;
    req_b[i*XLEN +: XLEN] = b;
    req_dest[i*TW +: TW]  = d;
  endtask

  task automatic wait_res(output int cyc);
    cyc = 0;
    while (res_valid !== 1'b1 && cyc < TMO) begin
      step();
      cyc++;
    end
  endtask

  task automatic test_reset();
    req_valid = 4'b0001;
    #3;
    n_chk++;
    if ({grant, mul_in_valid, res_valid, sched_busy, res_index, res_dest, res_data, mul_in_a, mul_in_b, mul_in_op} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got grant=%b miv=%b rv=%b busy=%b data=%h, required all 0", grant, mul_in_valid, res_valid, sched_busy, res_data);
    end
    req_valid = '0;
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_single();
    int   cyc;
    exp_t e;
    rob_head = 4'd1;
    set_entry(1, 32'd6, 32'd7, 4'd3);
    req_valid = 4'b0010;
    #1;
    n_chk++;
    if (grant !== 4'b0010) begin n_fail++; $display("FAIL single_grant: got %b required 0010", grant); end
    exp_q.push_back(mk(2'd1, 4'd3, 32'd42));
    step();
    req_valid = '0;
    n_chk++;
    if (mul_in_valid !== 1'b1 || mul_in_a !== 32'd6 || mul_in_b !== 32'd7) begin
      n_fail++; $display("FAIL single_issue: got miv=%b a=%0d b=%0d required 1 6 7", mul_in_valid, mul_in_a, mul_in_b);
    end
    wait_res(cyc);
    n_chk++;
    if (cyc !== 4) begin n_fail++; $display("FAIL single_latency: got res_valid %0d cycles after issue, required 4", cyc); end
    n_chk++;
    if (exp_q.size() == 0) begin n_fail++; $display("FAIL single_sb: scoreboard empty, required one entry"); end
    else begin
      e = exp_q.pop_front();
      n_chk++;
      if ({res_index, res_dest, res_data} !== e) begin
        n_fail++; $display("FAIL single_result: got idx=%0d dest=%0d data=%0d required idx=%0d dest=%0d data=%0d", res_index, res_dest, res_data, e.idx, e.dest, e.data);
      end
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    n_chk++;
    if (sched_busy !== 1'b0 || res_valid !== 1'b0) begin n_fail++; $display("FAIL single_idle: got busy=%b rv=%b required 0 0", sched_busy, res_valid); end
  endtask

  task automatic test_priority();
    rob_head = 4'd5;
    set_entry(0, 32'd1, 32'd1, 4'd6);
    set_entry(3, 32'd1, 32'd1, 4'd5);
    req_valid = 4'b1001;
    #1;
    n_chk++;
    if (grant !== 4'b1000) begin n_fail++; $display("FAIL age_zero: got %b required 1000", grant); end
    set_entry(1, 32'd1, 32'd1, 4'd7);
    set_entry(2, 32'd1, 32'd1, 4'd7);
    req_valid = 4'b0110;
    #1;
    n_chk++;
    if (grant !== 4'b0010) begin n_fail++; $display("FAIL tie_low: got %b required 0010", grant); end
    req_valid = '0;
    #1;
  endtask

  task automatic test_age_wrap();
    int   cyc;
    exp_t e;
    rob_head = 4'd14;
    set_entry(0, 32'd3, 32'd5, 4'd1);
    set_entry(2, 32'd9, 32'd11, 4'd15);
    req_valid = 4'b0101;
    #1;
    n_chk++;
    if (grant !== 4'b0100) begin n_fail++; $display("FAIL wrap_first: got %b required 0100", grant); end
    exp_q.push_back(mk(2'd2, 4'd15, 32'd99));
    step();
    req_valid = 4'b0001;
    wait_res(cyc);
    n_chk++;
    if (exp_q.size() == 0 || res_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_sb1: got rv=%b sb=%0d required 1 and entry", res_valid, exp_q.size()); end
    else begin
      e = exp_q.pop_front();
      n_chk++;
      if ({res_index, res_dest, res_data} !== e) begin
        n_fail++; $display("FAIL wrap_result1: got idx=%0d dest=%0d data=%0d required idx=%0d dest=%0d data=%0d", res_index, res_dest, res_data, e.idx, e.dest, e.data);
      end
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    n_chk++;
    if (grant !== 4'b0001) begin n_fail++; $display("FAIL wrap_second: got %b required 0001", grant); end
    exp_q.push_back(mk(2'd0, 4'd1, 32'd15));
    step();
    req_valid = '0;
    wait_res(cyc);
    n_chk++;
    if (exp_q.size() == 0 || res_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_sb2: got rv=%b sb=%0d required 1 and entry", res_valid, exp_q.size()); end
    else begin
      e = exp_q.pop_front();
      n_chk++;
      if ({res_index, res_dest, res_data} !== e) begin
        n_fail++; $display("FAIL wrap_result2: got idx=%0d dest=%0d data=%0d required idx=%0d dest=%0d data=%0d", res_index, res_dest, res_data, e.idx, e.dest, e.data);
      end
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int   cyc;
    exp_t e;
    rob_head = 4'd0;
    set_entry(3, 32'd100, 32'd200, 4'd2);
    req_valid = 4'b1000;
    #1;
    n_chk++;
    if (grant !== 4'b1000) begin n_fail++; $display("FAIL bp_grant: got %b required 1000", grant); end
    exp_q.push_back(mk(2'd3, 4'd2, 32'd20000));
    step();
    wait_res(cyc);
    for (int k = 0; k < 5; k++) begin
      n_chk++;
      if (res_valid !== 1'b1 || res_data !== 32'd20000 || grant !== 4'b0000) begin
        n_fail++; $display("FAIL bp_hold: cycle %0d got rv=%b data=%0d grant=%b required 1 20000 0000", k, res_valid, res_data, grant);
      end
      step();
    end
    n_chk++;
    if (exp_q.size() == 0) begin n_fail++; $display("FAIL bp_sb: scoreboard empty, required one entry"); end
    else begin
      e = exp_q.pop_front();
      n_chk++;
      if ({res_index, res_dest, res_data} !== e) begin
        n_fail++; $display("FAIL bp_result: got idx=%0d dest=%0d data=%0d required idx=%0d dest=%0d data=%0d", res_index, res_dest, res_data, e.idx, e.dest, e.data);
      end
    end
    req_valid = '0;
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  task automatic test_flush_wait();
    int   cyc;
    logic seen;
    exp_t e;
    rob_head = 4'd0;
    set_entry(0, 32'd2, 32'd3, 4'd4);
    req_valid = 4'b0001;
    #1;
    n_chk++;
    if (grant !== 4'b0001) begin n_fail++; $display("FAIL fw_grant: got %b required 0001", grant); end
    step();
    step();
    flush_pipeline = 1'b1;
    step();
    flush_pipeline = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < TMO; k++) begin
      n_chk++;
      if (grant !== 4'b0000 || res_valid !== 1'b0 || sched_busy !== 1'b1) begin
        n_fail++; $display("FAIL fw_drain: got grant=%b rv=%b busy=%b required 0000 0 1", grant, res_valid, sched_busy);
      end
      if (mul_out_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    n_chk++;
    if (seen !== 1'b1) begin n_fail++; $display("FAIL fw_unit_pulse: got no unit result, required one"); end
    step();
    n_chk++;
    if (grant !== 4'b0001 || res_valid !== 1'b0) begin n_fail++; $display("FAIL fw_regrant: got grant=%b rv=%b required 0001 0", grant, res_valid); end
    exp_q.push_back(mk(2'd0, 4'd4, 32'd6));
    step();
    req_valid = '0;
    wait_res(cyc);
    n_chk++;
    if (exp_q.size() == 0 || res_valid !== 1'b1) begin n_fail++; $display("FAIL fw_sb: got rv=%b sb=%0d required 1 and entry", res_valid, exp_q.size()); end
    else begin
      e = exp_q.pop_front();
      n_chk++;
      if ({res_index, res_dest, res_data} !== e) begin
        n_fail++; $display("FAIL fw_result: got idx=%0d dest=%0d data=%0d required idx=%0d dest=%0d data=%0d", res_index, res_dest, res_data, e.idx, e.dest, e.data);
      end
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  task automatic test_flush_issue();
    set_entry(1, 32'd5, 32'd5, 4'd6);
    req_valid = 4'b0010;
    #1;
    n_chk++;
    if (grant !== 4'b0010) begin n_fail++; $display("FAIL fi_grant: got %b required 0010", grant); end
    step();
    flush_pipeline = 1'b1;
    req_valid = '0;
    #1;
    n_chk++;
    if (mul_in_valid !== 1'b0) begin n_fail++; $display("FAIL fi_suppress: got miv=%b required 0", mul_in_valid); end
    step();
    flush_pipeline = 1'b0;
    n_chk++;
    if (sched_busy !== 1'b0) begin n_fail++; $display("FAIL fi_idle: got busy=%b required 0", sched_busy); end
    for (int k = 0; k < 6; k++) begin
      n_chk++;
      if (res_valid !== 1'b0 || mul_out_valid !== 1'b0) begin
        n_fail++; $display("FAIL fi_no_result: got rv=%b unit_out=%b required 0 0", res_valid, mul_out_valid);
      end
      step();
    end
  endtask

  task automatic test_async_reset();
    set_entry(2, 32'd8, 32'd9, 4'd7);
    req_valid = 4'b0100;
    #1;
    n_chk++;
    if (grant !== 4'b0100) begin n_fail++; $display("FAIL ar_grant: got %b required 0100", grant); end
    step();
    req_valid = '0;
    step();
    #1;
    reset = 1'b0;
    req_valid = 4'b0100;
    #1;
    n_chk++;
    if ({grant, mul_in_valid, res_valid, sched_busy, res_index, res_dest, res_data, mul_in_a, mul_in_b, mul_in_op} !== '0) begin
      n_fail++;
      $display("FAIL ar_outputs: got grant=%b miv=%b rv=%b busy=%b a=%h required all 0", grant, mul_in_valid, res_valid, sched_busy, mul_in_a);
    end
    step();
    req_valid = '0;
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      n_chk++;
      if (res_valid !== 1'b0 || sched_busy !== 1'b0) begin
        n_fail++; $display("FAIL ar_ignore_late: got rv=%b busy=%b required 0 0", res_valid, sched_busy);
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_age_wrap();
    test_backpressure();
    test_flush_wait();
    test_flush_issue();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
